nano_boot_loader: RTL
=====================

# nano_boot_loader

Program loader that sits between an external byte stream and the NanoCPU program/data memory. While loading, it holds the CPU in reset and writes received 16-bit words into memory from address 0 upward. It then verifies a checksum and releases the CPU. After release it passes the CPU's memory-port signals straight through to the memory.

## Interface
- `CSUM_EN`, default 1 — 1: a checksum byte follows the data; 0: no checksum byte, the block goes straight to RUN after the last write.
- `ck` input 1 — clock; all state changes on rising edge.
- `rst` input 1 — synchronous, active-low reset.
- `rx_data` input 8 — stream byte.
- `rx_valid` input 1 — `rx_data` is valid.
- `rx_ready` output 1 — block accepts a byte. A byte transfers on a rising edge where `rx_valid && rx_ready`.
- `cpu_address` input 8 — CPU memory address.
- `cpu_dataW` input 16 — CPU write data.
- `cpu_we` input 1 — CPU write enable.
- `cpu_ce` input 1 — CPU chip enable.
- `mem_address` output 8 — to memory.
- `mem_dataW` output 16 — to memory.
- `mem_we` output 1 — to memory.
- `mem_ce` output 1 — to memory.
- `cpu_rst` output 1 — active-high reset to NanoCPU.
- `done` output 1 — load complete, CPU running.
- `err` output 1 — checksum mismatch; sticky until `rst`.

## Operation
- Stream format:
  - count byte `N`: `N` = 1..255 words, `N` = 0 means 256 words;
  - then `N` words, each as a high byte followed by a low byte;
  - then, if `CSUM_EN`, one checksum byte equal to the XOR of every data byte (the count byte is excluded).
- States: `IDLE`, `HI`, `LO`, `WRITE`, `CSUM`, `RUN`, `ERR`.
- `IDLE`:
  - on transfer, `remain` <= `N` (9-bit, 0 -> 256), `ptr` <= 0, `csum` <= 0;
  - -> `HI`.
- `HI`: on transfer, `hi` <= byte, `csum` ^= byte; -> `LO`.
- `LO`: on transfer, `lo` <= byte, `csum` ^= byte; -> `WRITE`.
- `WRITE`: exactly one cycle.
  - `mem_ce` = `mem_we` = 1, `mem_address` = `ptr`, `mem_dataW` = {`hi`,`lo`};
  - then `ptr` <= `ptr`+1 (8-bit, wraps 0xFF -> 0x00), `remain` <= `remain`-1;
  - -> `HI` if `remain` != 1, else -> `CSUM` (`CSUM_EN`=1) or `RUN` (`CSUM_EN`=0).
- `CSUM`: on transfer, -> `RUN` if byte == `csum`, else -> `ERR`.
- `RUN`:
  - `mem_*` = `cpu_*` (combinational pass-through);
  - `cpu_rst` = 0, `done` = 1, `rx_ready` = 0;
  - stays until `rst`.
- `ERR`:
  - `err` = 1, `cpu_rst` = 1, `rx_ready` = 0;
  - memory port idle (`mem_we` = `mem_ce` = 0, `mem_address` = `ptr`, `mem_dataW` = {`hi`,`lo`});
  - stays until `rst`.
- Outside `RUN` and `WRITE`: `mem_we` = `mem_ce` = 0; `cpu_*` inputs are ignored.
- `rx_ready` = `rst` && state ∈ {`IDLE`,`HI`,`LO`,`CSUM`}.
- Bytes presented in `WRITE`, `RUN` or `ERR` are not consumed; the sender must hold them.

## Timing
- Reset values (cycle with `rst` = 0, and the register state afterwards):
  - state `IDLE`; `ptr`, `remain`, `hi`, `lo`, `csum` = 0;
  - `cpu_rst` = 1; `done` = `err` = 0; `mem_we` = `mem_ce` = 0; `rx_ready` = 0;
  - `rx_ready` = 1 in the first cycle with `rst` = 1.
- Per word: minimum 3 cycles (`HI`, `LO`, `WRITE`) with `rx_valid` held high.
- The memory write occurs at the rising edge that ends the `WRITE` cycle.
- `cpu_rst` falls in the cycle after the checksum byte transfer (after the last `WRITE` cycle when `CSUM_EN` = 0). The CPU's first fetch edge follows one cycle later.
- `cpu_rst`, `done` and `err` are decoded from the state register; they never glitch on stream inputs.
- RUN pass-through is purely combinational: zero-cycle latency, with `cpu_we` reaching memory in the same cycle.
- Reset mid-load:
  - returns to `IDLE`; words already written stay in memory;
  - `cpu_rst` remains 1 throughout.
- Reset in `RUN`: `cpu_rst` = 1 on the next edge, memory ownership returns to the loader.

## Structure
- Package `nano_pkg`:
  - state enum `boot_state_t`;
  - constants `NANO_ADDR_W` = 8, `NANO_DATA_W` = 16, shared with NanoCPU.
- One sub-module, `nano_mem_mux`: combinational selection between the loader write port and the CPU port, selected by `state == RUN`.
- FSM, counters and checksum live in `nano_boot_loader`.

## Test plan
- Stream `03 01 E0 01 F1 02 02 11`, `rx_valid` held high:
  - writes `mem[0]`=01E0, `mem[1]`=01F1, `mem[2]`=0202;
  - then `done` = 1, and `cpu_rst` falls one cycle after the `11` transfer.
- Same stream with checksum `12`: `err` = 1, `cpu_rst` stays 1, `rx_ready` = 0, and no further memory writes.
- Count `00` followed by 512 data bytes: 256 writes, the last at `mem_address` = FF, with `ptr` wrapping to 00.
- `rx_valid` toggling every other cycle, plus a byte presented during `WRITE`: no byte is lost or duplicated, and the memory image matches the stream.
- `rst` = 0 after the first word is written:
  - next cycle `rx_ready` = 1, state `IDLE`, `cpu_rst` = 1;
  - a fresh stream then loads correctly.
- In `RUN`, drive `cpu_ce` = 1, `cpu_we` = 1, `cpu_address` = 0F, `cpu_dataW` = 5555: `mem_*` equal those values in the same cycle, and `mem[15]` = 5555. Repeat with `CSUM_EN` = 0 and stream `01 AB CD`: `RUN` is entered immediately after the single write.

Source files
------------

// File: rtl/nano_boot_loader_pkg.sv
// nano_pkg: types and widths shared by the boot loader and NanoCPU.
//   boot_state_t - loader FSM states
//   NANO_ADDR_W  - memory address width
//   NANO_DATA_W  - memory word width
package nano_pkg;

  localparam int NANO_ADDR_W = 8;
  localparam int NANO_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HI    = 3'd1,
    LO    = 3'd2,
    WRITE = 3'd3,
    CSUM  = 3'd4,
    RUN   = 3'd5,
    ERR   = 3'd6
  } boot_state_t;

endpackage

// File: rtl/nano_boot_loader_if.sv
// nano_boot_loader_if: byte stream, CPU memory port and memory port of the
// boot loader.
//   rx_data/rx_valid/rx_ready                  - byte stream handshake
//   cpu_address/cpu_dataW/cpu_we/cpu_ce        - NanoCPU memory port
//   mem_address/mem_dataW/mem_we/mem_ce        - program/data memory port
// master: the environment side (sender, CPU, memory)
// slave : the loader side
interface nano_boot_loader_if;

  logic [7:0]                       rx_data;
  logic                             rx_valid;
  logic                             rx_ready;

  logic [nano_pkg::NANO_ADDR_W-1:0] cpu_address;
  logic [nano_pkg::NANO_DATA_W-1:0] cpu_dataW;
  logic                             cpu_we;
  logic                             cpu_ce;

  logic [nano_pkg::NANO_ADDR_W-1:0] mem_address;
  logic [nano_pkg::NANO_DATA_W-1:0] mem_dataW;
  logic                             mem_we;
  logic                             mem_ce;

  modport master (
    output rx_data, rx_valid, cpu_address, cpu_dataW, cpu_we, cpu_ce,
    input  rx_ready, mem_address, mem_dataW, mem_we, mem_ce
  );

  modport slave (
    input  rx_data, rx_valid, cpu_address, cpu_dataW, cpu_we, cpu_ce,
    output rx_ready, mem_address, mem_dataW, mem_we, mem_ce
  );

endinterface

// File: rtl/nano_mem_mux.sv
// nano_mem_mux: selects who drives the memory port.
//   sel_cpu      - 1: CPU port passes straight through; 0: loader port
//   ldr_*        - loader write port (ce follows we)
//   cpu_*        - NanoCPU memory port
//   mem_*        - memory port
module nano_mem_mux
  import nano_pkg::*;
(
  input  logic                   sel_cpu,
  input  logic [NANO_ADDR_W-1:0] ldr_address,
  input  logic [NANO_DATA_W-1:0] ldr_dataW,
  input  logic                   ldr_we,
  input  logic [NANO_ADDR_W-1:0] cpu_address,
  input  logic [NANO_DATA_W-1:0] cpu_dataW,
  input  logic                   cpu_we,
  input  logic                   cpu_ce,
  output logic [NANO_ADDR_W-1:0] mem_address,
  output logic [NANO_DATA_W-1:0] mem_dataW,
  output logic                   mem_we,
  output logic                   mem_ce
);

  assign mem_address = sel_cpu ? cpu_address : ldr_address;
  assign mem_dataW   = sel_cpu ? cpu_dataW   : ldr_dataW;
  assign mem_we      = sel_cpu ? cpu_we      : ldr_we;
  assign mem_ce      = sel_cpu ? cpu_ce      : ldr_we;

endmodule

// File: rtl/nano_boot_loader.sv
// nano_boot_loader: loads a word stream into NanoCPU memory while holding the
// CPU in reset, checks an optional XOR checksum, then hands the memory port
// to the CPU.
//   CSUM_EN - 1: a checksum byte follows the data
//   ck      - clock
//   rst     - synchronous active-low reset
//   bus     - stream / CPU / memory ports (slave side)
//   cpu_rst - active-high NanoCPU reset
//   done    - load complete, CPU running
//   err     - checksum mismatch, sticky until rst
//
// state | meaning
// IDLE  | waiting for the word count byte
// HI    | waiting for the high byte of a word
// LO    | waiting for the low byte of a word
// WRITE | one-cycle memory write of {hi,lo} at ptr
// CSUM  | waiting for the checksum byte
// RUN   | CPU released, memory port passed through
// ERR   | checksum mismatch, CPU held in reset
module nano_boot_loader
  import nano_pkg::*;
#(
  parameter bit CSUM_EN = 1'b1
) (
  input  logic              ck,
  input  logic              rst,
  nano_boot_loader_if.slave bus,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  boot_state_t            state, state_nxt;
  logic [8:0]             remain;
  logic [NANO_ADDR_W-1:0] ptr;
  logic [7:0]             hi, lo, csum;
  logic                   xfer;
  logic                   ldr_we;

  assign bus.rx_ready = rst && (state inside {IDLE, HI, LO, CSUM});
  assign xfer         = bus.rx_valid && bus.rx_ready;

  always_ff @(posedge ck) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge ck) begin
    if (!rst) begin
      remain <= '0;
      ptr    <= '0;
      hi     <= '0;
      lo     <= '0;
      csum   <= '0;
    end else begin
      case (state)
        IDLE: if (xfer) begin
          // a count of zero stands for a full 256-word image
          remain <= (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
          ptr    <= '0;
          csum   <= '0;
        end
        HI: if (xfer) begin
          hi   <= bus.rx_data;
          csum <= csum ^ bus.rx_data;
        end
        LO: if (xfer) begin
          lo   <= bus.rx_data;
          csum <= csum ^ bus.rx_data;
        end
        WRITE: begin
          ptr    <= ptr + 8'd1;
          remain <= remain - 9'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    ldr_we    = 1'b0;
    cpu_rst   = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    unique case (state)
      IDLE: if (xfer) state_nxt = HI;
      HI:   if (xfer) state_nxt = LO;
      LO:   if (xfer) state_nxt = WRITE;
      WRITE: begin
        ldr_we = 1'b1;
        if (remain != 9'd1) state_nxt = HI;
        else if (CSUM_EN)   state_nxt = CSUM;
        else                state_nxt = RUN;
      end
      CSUM: if (xfer) state_nxt = (bus.rx_data == csum) ? RUN : ERR;
      RUN: begin
        cpu_rst = 1'b0;
        done    = 1'b1;
      end
      ERR:     err = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  nano_mem_mux u_mem_mux (
    .sel_cpu     (state == RUN),
    .ldr_address (ptr),
    .ldr_dataW   ({hi, lo}),
    .ldr_we      (ldr_we),
    .cpu_address (bus.cpu_address),
    .cpu_dataW   (bus.cpu_dataW),
    .cpu_we      (bus.cpu_we),
    .cpu_ce      (bus.cpu_ce),
    .mem_address (bus.mem_address),
    .mem_dataW   (bus.mem_dataW),
    .mem_we      (bus.mem_we),
    .mem_ce      (bus.mem_ce)
  );

endmodule
